// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write-to-read bypass,
// per-register busy scoreboard and a dedicated stack-pointer adjust path.
module regfile_sb #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 5,
    parameter int          SP_IDX   = 29,
    parameter logic [63:0] SP_RESET = 64'h0000_FFFC,
    parameter int          SP_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              sp_inc,
    input  logic              sp_dec,
    output logic [DATA_W-1:0] sp_out
);

    localparam int                NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_A   = ADDR_W'(SP_IDX);
    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RESET);
    localparam logic [DATA_W-1:0] STEP   = DATA_W'(SP_STEP);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    logic wr_en;
    logic sp_wr;
    logic iss_en;
    logic byp1;
    logic byp2;

    assign wr_en  = we && (waddr != '0);
    assign sp_wr  = wr_en && (waddr == SP_A);
    assign iss_en = issue_en && (issue_addr != '0);

    // Register next state: write port first, then SP adjust unless written
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
        if (!sp_wr && (SP_A != '0) && (sp_inc ^ sp_dec)) begin
            if (sp_inc) begin
                regs_d[SP_A] = regs_q[SP_A] + STEP;
            end else begin
                regs_d[SP_A] = regs_q[SP_A] - STEP;
            end
        end
        regs_d[0] = '0;
    end

    // Scoreboard next state: retire clears, a new issue to the same reg wins
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[waddr] = 1'b0;
        end
        if (iss_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset to the defined contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                if ((i == SP_IDX) && (i != 0)) begin
                    regs_q[i] <= SP_RST;
                end else begin
                    regs_q[i] <= '0;
                end
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Bypass hits are suppressed while reset holds the array
    always_comb begin
        byp1 = !rst && we && (waddr == raddr1);
        byp2 = !rst && we && (waddr == raddr2);
    end

    // Read port 1: reg0 is zero, then bypass, then storage
    always_comb begin
        rdata1 = '0;
        busy1  = 1'b0;
        if (raddr1 != '0) begin
            rdata1 = byp1 ? wdata : regs_q[raddr1];
            busy1  = busy_q[raddr1] && !byp1;
        end
    end

    // Read port 2: same selection as port 1
    always_comb begin
        rdata2 = '0;
        busy2  = 1'b0;
        if (raddr2 != '0) begin
            rdata2 = byp2 ? wdata : regs_q[raddr2];
            busy2  = busy_q[raddr2] && !byp2;
        end
    end

    assign sp_out = regs_q[SP_A];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard-driven bench for regfile_sb, default and
// narrow (16-bit, 8-entry) configurations.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        busy1;
    logic        busy2;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        sp_inc;
    logic        sp_dec;
    logic [31:0] sp_out;

    logic        p_rst;
    logic        p_we;
    logic [2:0]  p_waddr;
    logic [15:0] p_wdata;
    logic [2:0]  p_raddr1;
    logic [2:0]  p_raddr2;
    logic [15:0] p_rdata1;
    logic [15:0] p_rdata2;
    logic        p_busy1;
    logic        p_busy2;
    logic        p_issue_en;
    logic [2:0]  p_issue_addr;
    logic        p_sp_inc;
    logic        p_sp_dec;
    logic [15:0] p_sp_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_out(sp_out)
    );

    regfile_sb #(
        .DATA_W(16), .ADDR_W(3), .SP_IDX(6),
        .SP_RESET(64'h00F0), .SP_STEP(2)
    ) dut_p (
        .clk(clk), .rst(p_rst), .we(p_we), .waddr(p_waddr),
        .wdata(p_wdata), .raddr1(p_raddr1), .raddr2(p_raddr2),
        .rdata1(p_rdata1), .rdata2(p_rdata2),
        .busy1(p_busy1), .busy2(p_busy2),
        .issue_en(p_issue_en), .issue_addr(p_issue_addr),
        .sp_inc(p_sp_inc), .sp_dec(p_sp_dec), .sp_out(p_sp_out)
    );

    task automatic idle();
        we = 0; issue_en = 0; sp_inc = 0; sp_dec = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        raddr1 = 5'd29;
        exp_q.push_back(32'h0000_FFFC);
        exp_q.push_back(32'h0000_FFFC);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL rst_sp_init: got %h want %h", sp_out, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL rst_r29_init: got %h want %h", rdata1, e);
        end
        checks++;
        @(negedge clk);
        we = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
        issue_en = 1; issue_addr = 5;
        @(negedge clk);
        idle();
        raddr1 = 5; raddr2 = 5;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL rst_pre_rd: got %h want %h", rdata1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL rst_pre_busy: got %h want %h", busy1, e);
        end
        checks++;
        #2;
        rst = 1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_FFFC);
        #1;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL rst_rd1: got %h want %h", rdata1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL rst_busy1: got %h want %h", busy1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if ({31'b0, busy2} !== e) begin
            errors++; $display("FAIL rst_busy2: got %h want %h", busy2, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL rst_sp: got %h want %h", sp_out, e);
        end
        checks++;
        @(negedge clk);
        rst = 0;
        raddr2 = 5'd29;
        exp_q.push_back(32'h0000_FFFC);
        #1;
        e = exp_q.pop_front();
        if (rdata2 !== e) begin
            errors++; $display("FAIL rst_r29: got %h want %h", rdata2, e);
        end
        checks++;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1; waddr = 7; wdata = 32'h1234_5678;
        raddr1 = 7; raddr2 = 7;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(32'h1234_5678);
            exp_q.push_back(32'h1234_5678);
            #1;
            e = exp_q.pop_front();
            if (rdata1 !== e) begin
                errors++;
                $display("FAIL byp_rd1_%0d: got %h want %h", k, rdata1, e);
            end
            checks++;
            e = exp_q.pop_front();
            if (rdata2 !== e) begin
                errors++;
                $display("FAIL byp_rd2_%0d: got %h want %h", k, rdata2, e);
            end
            checks++;
            @(negedge clk);
            idle();
        end
        we = 1; waddr = 0; wdata = 32'hFFFF_FFFF;
        issue_en = 1; issue_addr = 0;
        raddr1 = 0; raddr2 = 0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            #1;
            e = exp_q.pop_front();
            if (rdata1 !== e) begin
                errors++;
                $display("FAIL r0_rd_%0d: got %h want %h", k, rdata1, e);
            end
            checks++;
            e = exp_q.pop_front();
            if ({31'b0, busy1} !== e) begin
                errors++;
                $display("FAIL r0_busy_%0d: got %h want %h", k, busy1, e);
            end
            checks++;
            @(negedge clk);
            idle();
        end
    endtask

    task automatic test_sp();
        do_reset();
        raddr1 = 29;
        sp_dec = 1;
        repeat (3) @(negedge clk);
        sp_dec = 0;
        exp_q.push_back(32'h0000_FFF0);
        exp_q.push_back(32'h0000_FFF0);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL sp_dec3: got %h want %h", sp_out, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL sp_dec3_rd: got %h want %h", rdata1, e);
        end
        checks++;
        sp_inc = 1; sp_dec = 1;
        @(negedge clk);
        idle();
        exp_q.push_back(32'h0000_FFF0);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL sp_both: got %h want %h", sp_out, e);
        end
        checks++;
        we = 1; waddr = 29; wdata = 32'h0; sp_inc = 1;
        exp_q.push_back(32'h0000_FFF0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL sp_wr_nobyp: got %h want %h", sp_out, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL sp_wr_byp: got %h want %h", rdata1, e);
        end
        checks++;
        @(negedge clk);
        idle();
        sp_dec = 1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL sp_wr_wins: got %h want %h", sp_out, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL sp_adj_nobyp: got %h want %h", rdata1, e);
        end
        checks++;
        @(negedge clk);
        idle();
        exp_q.push_back(32'hFFFF_FFFC);
        #1;
        e = exp_q.pop_front();
        if (sp_out !== e) begin
            errors++; $display("FAIL sp_wrap: got %h want %h", sp_out, e);
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        raddr1 = 9; raddr2 = 9;
        issue_en = 1; issue_addr = 9;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL sb_pre: got %h want %h", busy1, e);
        end
        checks++;
        @(negedge clk);
        idle();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        #1;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL sb_set1: got %h want %h", busy1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if ({31'b0, busy2} !== e) begin
            errors++; $display("FAIL sb_set2: got %h want %h", busy2, e);
        end
        checks++;
        we = 1; waddr = 9; wdata = 32'hA5A5_5A5A;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hA5A5_5A5A);
        #1;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL sb_retire: got %h want %h", busy1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL sb_retire_rd: got %h want %h", rdata1, e);
        end
        checks++;
        @(negedge clk);
        idle();
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if ({31'b0, busy2} !== e) begin
            errors++; $display("FAIL sb_clr: got %h want %h", busy2, e);
        end
        checks++;
        issue_en = 1; issue_addr = 9;
        @(negedge clk);
        we = 1; waddr = 9; wdata = 32'h0000_0001;
        issue_en = 1; issue_addr = 9;
        @(negedge clk);
        idle();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0000_0001);
        #1;
        e = exp_q.pop_front();
        if ({31'b0, busy1} !== e) begin
            errors++; $display("FAIL sb_set_wins: got %h want %h", busy1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if (rdata1 !== e) begin
            errors++; $display("FAIL sb_set_wins_rd: got %h want %h", rdata1, e);
        end
        checks++;
        we = 1; waddr = 9; wdata = 32'h2;
        @(negedge clk);
        idle();
    endtask

    task automatic test_param_sweep();
        logic [15:0] v;
        p_we = 0; p_issue_en = 0; p_sp_inc = 0; p_sp_dec = 0;
        p_rst = 1;
        @(negedge clk);
        p_rst = 0;
        p_raddr1 = 6; p_raddr2 = 0;
        exp_q.push_back(32'h00F0);
        exp_q.push_back(32'h00F0);
        #1;
        e = exp_q.pop_front();
        if ({16'h0, p_rdata1} !== e) begin
            errors++; $display("FAIL p_rst_r6: got %h want %h", p_rdata1, e);
        end
        checks++;
        e = exp_q.pop_front();
        if ({16'h0, p_sp_out} !== e) begin
            errors++; $display("FAIL p_rst_sp: got %h want %h", p_sp_out, e);
        end
        checks++;
        p_sp_inc = 1;
        @(negedge clk);
        p_sp_inc = 0;
        exp_q.push_back(32'h00F2);
        #1;
        e = exp_q.pop_front();
        if ({16'h0, p_sp_out} !== e) begin
            errors++; $display("FAIL p_sp_inc: got %h want %h", p_sp_out, e);
        end
        checks++;
        for (int i = 1; i < 8; i++) begin
            v = 16'(i * 16'h1111) ^ 16'hA50F;
            p_we = 1; p_waddr = 3'(i); p_wdata = v;
            exp_q.push_back({16'h0, v});
            @(negedge clk);
        end
        p_we = 0;
        for (int i = 1; i < 8; i++) begin
            p_raddr1 = 3'(i); p_raddr2 = 3'(8 - i);
            #1;
            e = exp_q.pop_front();
            if ({16'h0, p_rdata1} !== e) begin
                errors++;
                $display("FAIL p_rd_r%0d: got %h want %h", i, p_rdata1, e);
            end
            checks++;
            @(negedge clk);
        end
        p_raddr1 = 0;
        exp_q.push_back(32'h0);
        #1;
        e = exp_q.pop_front();
        if ({16'h0, p_rdata1} !== e) begin
            errors++; $display("FAIL p_r0: got %h want %h", p_rdata1, e);
        end
        checks++;
    endtask

    initial begin
        rst = 1; p_rst = 1;
        idle();
        waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0; issue_addr = 0;
        p_we = 0; p_waddr = 0; p_wdata = 0; p_raddr1 = 0; p_raddr2 = 0;
        p_issue_en = 0; p_issue_addr = 0; p_sp_inc = 0; p_sp_dec = 0;
        test_reset();
        test_bypass();
        test_sp();
        test_scoreboard();
        test_param_sweep();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_left: got %0d want 0", exp_q.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
